// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer: circular FIFO of {instruction, PC} pairs between
// fetch and decode. Accept/valid depend on registered occupancy only, so there
// is no combinational path from the inputs to the outputs.
// Optional build macro INST_FETCH_BUFFER_STATS_EN adds flush/full statistics
// counters and a per-flush report line.
module inst_fetch_buffer #(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20,
  parameter int DEPTH        = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [DATA_WIDTH-1:0]     in_instruction,
  input  logic [ADDRESS_BITS-1:0]   in_PC,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     out_instruction,
  output logic [ADDRESS_BITS-1:0]   out_PC,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]        FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] NOP        = DATA_WIDTH'(32'h0000_0013);

  // Reject unsupported geometries at elaboration time.
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || CORE < 0) begin : g_bad_param
    $error("inst_fetch_buffer: DEPTH must be a power of two in 2..16 and CORE >= 0");
  end

  logic [DATA_WIDTH-1:0]   instr_mem [DEPTH];
  logic [ADDRESS_BITS-1:0] pc_mem    [DEPTH];
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W:0]          count_q;
  logic                    push;
  logic                    pop;

  // A full buffer refuses input even if the head leaves in the same cycle.
  assign in_ready  = (count_q < FULL_COUNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign count     = count_q;

  // Head presentation: NOP with PC 0 whenever the buffer is empty.
  always_comb begin
    out_instruction = NOP;
    out_PC          = '0;
    if (out_valid) begin
      out_instruction = instr_mem[rd_ptr];
      out_PC          = pc_mem[rd_ptr];
    end
  end

  // Entry storage; contents are never cleared, occupancy decides validity.
  always_ff @(posedge clock) begin
    if (push) begin
      instr_mem[wr_ptr] <= in_instruction;
      pc_mem[wr_ptr]    <= in_PC;
    end
  end

  // Pointers and occupancy; reset beats flush, flush beats push/pop.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef INST_FETCH_BUFFER_STATS_EN
  logic [31:0] flushed_entries;
  logic [31:0] full_cycles;
  logic [32:0] flushed_sum;
  logic [31:0] flushed_next;
  logic [31:0] full_next;

  // Saturating next values for both statistics counters.
  always_comb begin
    flushed_sum  = {1'b0, flushed_entries} + 33'(count_q);
    flushed_next = flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
    full_next    = full_cycles;
    if (count_q == FULL_COUNT && full_cycles != 32'hFFFF_FFFF) begin
      full_next = full_cycles + 32'd1;
    end
  end

  // Statistics registers plus a report line on every flush.
  always_ff @(posedge clock) begin
    if (!reset) begin
      flushed_entries <= '0;
      full_cycles     <= '0;
    end else begin
      full_cycles <= full_next;
      if (flush) begin
        flushed_entries <= flushed_next;
        $display("Core %0d IFB flushed=%0d full=%0d", CORE, flushed_next, full_next);
      end
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Self-checking bench for inst_fetch_buffer: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// queue-based reference model.
module tb_inst_fetch_buffer;

  localparam int DW    = 32;
  localparam int AW    = 20;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_instruction;
  logic [AW-1:0] in_PC;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_instruction;
  logic [AW-1:0] out_PC;
  logic          out_ready;
  logic [2:0]    count;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  typedef struct packed {
    logic [DW-1:0] instr;
    logic [AW-1:0] pc;
  } entry_t;

  entry_t model_q[$];

  inst_fetch_buffer #(.CORE(0), .DATA_WIDTH(DW), .ADDRESS_BITS(AW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_instruction(in_instruction), .in_PC(in_PC),
    .in_ready(in_ready), .out_valid(out_valid), .out_instruction(out_instruction),
    .out_PC(out_PC), .out_ready(out_ready), .count(count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: FIFO rules applied to a queue at each rising edge.
  always @(posedge clock) begin
    if (!reset || flush) begin
      model_q.delete();
    end else begin
      bit do_push;
      bit do_pop;
      do_push = in_valid && (model_q.size() < DEPTH);
      do_pop  = out_ready && (model_q.size() != 0);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back('{instr: in_instruction, pc: in_PC});
    end
  end

  // Compare DUT outputs with the model on every falling edge.
  always @(negedge clock) begin
    if (started) begin
      int n;
      n = model_q.size();
      chk("count", 32'(count), 32'(n));
      chk("out_valid", 32'(out_valid), 32'(n != 0));
      chk("in_ready", 32'(in_ready), 32'(n < DEPTH));
      chk("out_instruction", out_instruction, (n != 0) ? model_q[0].instr : 32'h0000_0013);
      chk("out_PC", 32'(out_PC), (n != 0) ? 32'(model_q[0].pc) : 32'h0);
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit iv, input logic [AW-1:0] pc, input bit ordy, input bit fl);
    in_valid       = iv;
    in_PC          = pc;
    in_instruction = $urandom;
    out_ready      = ordy;
    flush          = fl;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, '0, 0, 0);
    repeat (2) cyc();
    reset = 1'b1;
    started = 1;

    // Reset state
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_instruction", out_instruction, 32'h0000_0013);
    chk("rst_out_PC", 32'(out_PC), 0);

    // Fill to full with decode stalled; fifth push is refused
    for (int i = 0; i < 5; i++) begin
      drive(1, AW'(i * 4), 0, 0);
      cyc();
    end
    chk("full_count", 32'(count), 4);
    chk("full_in_ready", 32'(in_ready), 0);
    drive(0, '0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", 32'(out_PC), 32'(i * 4));
      cyc();
    end
    chk("drain_count", 32'(count), 0);
    chk("drain_out_valid", 32'(out_valid), 0);

    // Steady stream at occupancy 2, pointers wrap
    for (int i = 0; i < 2; i++) begin
      drive(1, AW'(32'h200 + i * 4), 0, 0);
      cyc();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1, AW'(32'h208 + i * 4), 1, 0);
      chk("stream_pc", 32'(out_PC), 32'h200 + 32'(i * 4));
      cyc();
      chk("stream_count", 32'(count), 2);
    end

    // Flush at occupancy 3 with a pending push
    drive(1, AW'(32'h300), 0, 1);
    cyc();
    for (int i = 0; i < 3; i++) begin
      drive(1, AW'(32'h300 + i * 4), 0, 0);
      cyc();
    end
    chk("preflush_count", 32'(count), 3);
`ifdef INST_FETCH_BUFFER_STATS_EN
    begin
      logic [31:0] before;
      before = dut.flushed_entries;
      drive(1, AW'(32'h040), 1, 1);
      cyc();
      chk("flushed_entries_delta", dut.flushed_entries - before, 3);
    end
`else
    drive(1, AW'(32'h040), 1, 1);
    cyc();
`endif
    chk("flush_count", 32'(count), 0);
    chk("flush_out_valid", 32'(out_valid), 0);
    drive(0, '0, 1, 0);
    cyc();
    chk("flush_no_040", 32'(out_valid), 0);

    // Full with simultaneous pop and push attempt
    for (int i = 0; i < 4; i++) begin
      drive(1, AW'(32'h400 + i * 4), 0, 0);
      cyc();
    end
    drive(1, AW'(32'h410), 1, 0);
    cyc();
    chk("fullpop_count", 32'(count), 3);
    chk("fullpop_in_ready", 32'(in_ready), 1);
    chk("fullpop_pc", 32'(out_PC), 32'h404);
    drive(0, '0, 1, 0);
    repeat (3) cyc();
    chk("fullpop_drained", 32'(count), 0);

    // Reset mid-stream
    for (int i = 0; i < 3; i++) begin
      drive(1, AW'(32'h500 + i * 4), 0, 0);
      cyc();
    end
    drive(0, '0, 0, 0);
    reset = 1'b0;
    cyc();
    chk("midrst_count", 32'(count), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    reset = 1'b1;
    drive(1, AW'(32'h100), 0, 0);
    cyc();
    chk("postrst_pc", 32'(out_PC), 32'h100);
    chk("postrst_count", 32'(count), 1);
    drive(0, '0, 0, 1);
    cyc();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, AW'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 24) == 0);
      reset = ($urandom_range(0, 99) != 0);
      cyc();
    end
    reset = 1'b1;
    drive(0, '0, 0, 0);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
